// File: rtl/hawk_pgrd_mngr_pkg.sv
// Shared types and constants for the HAWK page read manager.
// Mirrors the page-writer request packet so the control unit can drive either side.
package hawk_pgrd_mngr_pkg;

  localparam int unsigned HAWK_CL_BYTES  = 64;
  localparam int unsigned CL_OFS_W       = $clog2(HAWK_CL_BYTES);
  localparam int unsigned NBLK_W         = 7;
  localparam logic [2:0]  AXI_SIZE_CL    = 3'd6;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [63:0]       addr;
    logic [NBLK_W-1:0] nblk;
    logic              vld;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic rdy;
  } axi_rd_rdypkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pgrd_state_t;

  // Reads issued but not yet handed to the consumer; this is the credit in use.
  function automatic logic [NBLK_W-1:0] credits_used(input logic [NBLK_W-1:0] issued,
                                                     input logic [NBLK_W-1:0] delivered);
    return issued - delivered;
  endfunction

endpackage

// File: rtl/hawk_rd_fifo.sv
// Registered synchronous FIFO holding returned cachelines plus their error flag.
// DEPTH must be a power of two; the head reads as zero while empty.
module hawk_rd_fifo #(
  parameter int unsigned WIDTH = 513,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is taken only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hawk_pgrd_mngr.sv
// Page read manager: turns one page-read command into single-cacheline AXI reads
// and delivers the returned lines, in order, through a credit-protected FIFO.
module hawk_pgrd_mngr
  import hawk_pgrd_mngr_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [6:0]        rd_req_nblk,
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic              blk_vld,
  input  logic              blk_rdy,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_err,
  output logic              blk_last,
  output logic              rd_done,
  output logic              rd_err,
  output pgrd_state_t       dbg_state_o
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; a raised valid and its payload are held until that edge.

  localparam logic [NBLK_W-1:0] DEPTH_C = NBLK_W'(FIFO_DEPTH);

  pgrd_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic [NBLK_W-1:0] ar_cnt_q, ar_cnt_d;
  logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic              rd_err_q, rd_err_d;

  logic              ar_hs, r_hs, blk_hs;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [NBLK_W-1:0] outst;
  logic              unused_in;

  assign outst  = credits_used(ar_cnt_q, blk_cnt_q);
  assign ar_hs  = axi_arvalid & axi_arready;
  assign r_hs   = axi_rvalid & axi_rready;
  assign blk_hs = blk_vld & blk_rdy;

  // arvalid is a function of registered state only: without an AR handshake
  // ar_cnt is frozen and blk_cnt can only grow, so a raised request stays raised.
  assign axi_arvalid = (state_q == ISSUE) && (ar_cnt_q != nblk_q) && (outst < DEPTH_C);
  assign axi_araddr  = base_q + ADDR_W'({ar_cnt_q, {CL_OFS_W{1'b0}}});
  assign axi_arid    = ID_W'(AXI_ID);
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = AXI_SIZE_CL;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_rready  = (state_q == ISSUE) || (state_q == DRAIN);

  assign rd_req_rdy  = (state_q == IDLE);
  assign rd_done     = (state_q == DONE);
  assign rd_err      = rd_err_q;
  assign dbg_state_o = state_q;

  assign blk_vld  = ~fifo_empty;
  assign blk_data = fifo_head[DATA_W:1];
  assign blk_err  = fifo_head[0];
  assign blk_last = blk_vld && (blk_cnt_q == nblk_q - 1'b1);

  assign unused_in = ^{axi_rid, axi_rlast, fifo_full, rd_req_addr[CL_OFS_W-1:0]};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nblk_d    = nblk_q;
    ar_cnt_d  = ar_cnt_q;
    blk_cnt_d = blk_cnt_q;
    rd_err_d  = rd_err_q;

    if (ar_hs)  ar_cnt_d  = ar_cnt_q + 1'b1;
    if (blk_hs) blk_cnt_d = blk_cnt_q + 1'b1;
    if (r_hs && (axi_rresp != 2'b00)) rd_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rd_req_vld) begin
          base_d    = {rd_req_addr[ADDR_W-1:CL_OFS_W], {CL_OFS_W{1'b0}}};
          nblk_d    = rd_req_nblk;
          ar_cnt_d  = '0;
          blk_cnt_d = '0;
          rd_err_d  = 1'b0;
          state_d   = (rd_req_nblk == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs && (ar_cnt_q + 1'b1 == nblk_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (blk_hs && (blk_cnt_q + 1'b1 == nblk_q)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      nblk_q    <= '0;
      ar_cnt_q  <= '0;
      blk_cnt_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nblk_q    <= nblk_d;
      ar_cnt_q  <= ar_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Credit keeps outstanding reads within FIFO_DEPTH, so a push always finds space.
  hawk_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (r_hs),
    .wdata_i ({axi_rdata, (axi_rresp != 2'b00)}),
    .pop_i   (blk_hs),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_hawk_pgrd_mngr.sv
// Self-checking bench for hawk_pgrd_mngr: directed commands, an AXI read responder
// returning address-tagged lines, and a monitor scoring AR and blk traffic.
module tb_hawk_pgrd_mngr;
  import hawk_pgrd_mngr_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          rd_req_vld, rd_req_rdy;
  logic [63:0]   rd_req_addr;
  logic [6:0]    rd_req_nblk;
  logic [3:0]    axi_arid;
  logic [63:0]   axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid, axi_arready;
  logic [3:0]    axi_rid;
  logic [511:0]  axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast, axi_rvalid, axi_rready;
  logic          blk_vld, blk_rdy;
  logic [511:0]  blk_data;
  logic          blk_err, blk_last, rd_done, rd_err;
  pgrd_state_t   dbg_state;

  logic [63:0]   exp_ar_q[$];
  logic [65:0]   exp_blk_q[$];   // {last, err, address tag}
  logic [63:0]   pend_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_ar     = 0;
  int err_beat = -1;
  int r_beat   = 0;

  always #5 clk = ~clk;

  hawk_pgrd_mngr #(
    .ADDR_W(64), .DATA_W(512), .ID_W(4), .AXI_ID(0), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .rd_req_nblk(rd_req_nblk),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_data(blk_data),
    .blk_err(blk_err), .blk_last(blk_last),
    .rd_done(rd_done), .rd_err(rd_err), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_rd_req_rdy"}, rd_req_rdy, 1'b1);
    chk({tag, "_arvalid"}, axi_arvalid, 1'b0);
    chk({tag, "_araddr"}, axi_araddr, 64'h0);
    chk({tag, "_rready"}, axi_rready, 1'b0);
    chk({tag, "_blk_vld"}, blk_vld, 1'b0);
    chk({tag, "_blk_data"}, blk_data, 512'h0);
    chk({tag, "_blk_err"}, blk_err, 1'b0);
    chk({tag, "_blk_last"}, blk_last, 1'b0);
    chk({tag, "_rd_done"}, rd_done, 1'b0);
    chk({tag, "_rd_err"}, rd_err, 1'b0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic push_seq(input logic [63:0] base, input int n, input int errb);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a;
      a = base + 64'(i) * 64'd64;
      exp_ar_q.push_back(a);
      exp_blk_q.push_back({(i == n - 1), (i == errb), a});
    end
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [6:0] n);
    int w;
    w = 0;
    @(posedge clk); #1;
    rd_req_vld = 1'b1; rd_req_addr = a; rd_req_nblk = n;
    do begin @(negedge clk); w++; end while (!rd_req_rdy && w < 200);
    if (!rd_req_rdy) chk("cmd_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    rd_req_vld = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (!rd_done && w < 1000);
    if (!rd_done) chk({nm, "_done_timeout"}, 1'b0, 1'b1);
  endtask

  // AXI read responder: one beat per cycle, data tagged with its address.
  initial begin : responder
    logic ar_f, r_f, acc;
    logic [63:0] ar_a, a;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rid = '0; axi_rlast = 1'b1;
    forever begin
      @(negedge clk);
      ar_f = axi_arvalid & axi_arready;
      ar_a = axi_araddr;
      r_f  = axi_rvalid & axi_rready;
      acc  = rd_req_vld & rd_req_rdy;
      @(posedge clk); #1;
      if (!rst_ni) begin
        pend_q.delete();
        axi_rvalid = 1'b0;
        r_beat = 0;
      end else begin
        if (acc) r_beat = 0;
        if (ar_f) pend_q.push_back(ar_a);
        if (r_f || !axi_rvalid) begin
          if (pend_q.size() > 0) begin
            a = pend_q.pop_front();
            axi_rvalid = 1'b1;
            axi_rdata  = {8{a}};
            axi_rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
            r_beat++;
          end else begin
            axi_rvalid = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: scores every AR and blk handshake plus rd_done timing and credit.
  initial begin : monitor
    logic done_pend, prev_vld, prev_rdy, prev_done;
    logic [63:0] prev_addr, ea;
    logic [65:0] e;
    int outst;
    done_pend = 1'b0; prev_vld = 1'b0; prev_rdy = 1'b0; prev_done = 1'b0;
    prev_addr = '0; outst = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        done_pend = 1'b0; prev_vld = 1'b0; prev_done = 1'b0; outst = 0;
        continue;
      end
      if (prev_vld && !prev_rdy) begin
        chk("ar_hold_vld", axi_arvalid, 1'b1);
        chk("ar_hold_addr", axi_araddr, prev_addr);
      end
      if (axi_arvalid && axi_arready) begin
        n_ar++;
        chk("ar_credit", (outst < 4), 1'b1);
        if (exp_ar_q.size() == 0) chk("ar_unexpected", axi_araddr, 64'hDEAD);
        else begin
          ea = exp_ar_q.pop_front();
          chk("ar_addr", axi_araddr, ea);
        end
      end
      if (blk_vld && blk_rdy) begin
        if (exp_blk_q.size() == 0) chk("blk_unexpected", blk_data, 512'h0);
        else begin
          e = exp_blk_q.pop_front();
          chk("blk_data", blk_data, {8{e[63:0]}});
          chk("blk_err", blk_err, e[64]);
          chk("blk_last", blk_last, e[65]);
        end
      end
      if (rd_done || done_pend) chk("rd_done_timing", rd_done, done_pend);
      if (rd_done) chk("rdy_low_in_done", rd_req_rdy, 1'b0);
      if (prev_done) chk("rdy_after_done", rd_req_rdy, 1'b1);
      outst = outst + int'(axi_arvalid && axi_arready) - int'(blk_vld && blk_rdy);
      done_pend = (blk_vld && blk_rdy && blk_last) ||
                  (rd_req_vld && rd_req_rdy && (rd_req_nblk == 7'd0));
      prev_vld  = axi_arvalid;
      prev_rdy  = axi_arready;
      prev_addr = axi_araddr;
      prev_done = rd_done;
    end
  end

  initial begin : stim
    int ar0;
    rst_ni = 1'b0; rd_req_vld = 1'b0; rd_req_addr = '0; rd_req_nblk = '0;
    axi_arready = 1'b1; blk_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_rst("rst");
    #2 rst_ni = 1'b1;
    @(negedge clk);
    check_rst("post_rst");
    chk("arlen", axi_arlen, 8'd0);
    chk("arsize", axi_arsize, 3'd6);
    chk("arburst", axi_arburst, 2'b01);
    chk("arid", axi_arid, 4'd0);

    // Basic four-line read
    exp_ar_q.push_back(64'h1000); exp_blk_q.push_back({1'b0, 1'b0, 64'h1000});
    exp_ar_q.push_back(64'h1040); exp_blk_q.push_back({1'b0, 1'b0, 64'h1040});
    exp_ar_q.push_back(64'h1080); exp_blk_q.push_back({1'b0, 1'b0, 64'h1080});
    exp_ar_q.push_back(64'h10C0); exp_blk_q.push_back({1'b1, 1'b0, 64'h10C0});
    send_cmd(64'h1000, 7'd4);
    wait_done("basic");

    // Error on the second beat; rd_err sticks until the next accept
    err_beat = 1;
    push_seq(64'h2000, 3, 1);
    send_cmd(64'h2000, 7'd3);
    wait_done("err");
    chk("rd_err_sticky", rd_err, 1'b1);
    err_beat = -1;

    // Zero-length command
    send_cmd(64'h7000, 7'd0);
    @(negedge clk);
    chk("zero_rd_done", rd_done, 1'b1);
    chk("rd_err_cleared", rd_err, 1'b0);
    chk("zero_no_arvalid", axi_arvalid, 1'b0);

    // Address wrap at the top of the space
    exp_ar_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
    exp_blk_q.push_back({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0});
    exp_ar_q.push_back(64'h0);
    exp_blk_q.push_back({1'b1, 1'b0, 64'h0});
    send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 7'd2);
    wait_done("wrap");

    // Unaligned base is truncated to its cacheline
    push_seq(64'h1000, 1, -1);
    send_cmd(64'h1025, 7'd1);
    wait_done("unaligned");

    // arready stall mid-command
    push_seq(64'h3000, 4, -1);
    send_cmd(64'h3000, 7'd4);
    @(posedge clk); #1 axi_arready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_arvalid", axi_arvalid, 1'b1);
    chk("stall_araddr", axi_araddr, 64'h3040);
    repeat (2) @(posedge clk);
    #1 axi_arready = 1'b1;
    wait_done("stall");

    // Consumer backpressure: credit caps outstanding reads at FIFO_DEPTH
    blk_rdy = 1'b0;
    push_seq(64'h10000, 64, -1);
    ar0 = n_ar;
    send_cmd(64'h10000, 7'd64);
    repeat (50) @(negedge clk);
    chk("bp_ar_count", n_ar - ar0, 4);
    chk("bp_arvalid_low", axi_arvalid, 1'b0);
    chk("bp_blk_vld", blk_vld, 1'b1);
    @(posedge clk); #1 blk_rdy = 1'b1;
    wait_done("bp");

    // Reset while two lines sit in the FIFO
    blk_rdy = 1'b0;
    push_seq(64'h4000, 2, -1);
    send_cmd(64'h4000, 7'd2);
    repeat (8) @(negedge clk);
    chk("mid_state", dbg_state, DRAIN);
    chk("mid_buffered", blk_vld, 1'b1);
    #2 rst_ni = 1'b0;
    #1 check_rst("mid_rst");
    exp_ar_q.delete();
    exp_blk_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    blk_rdy = 1'b1;

    // New command after the mid-command reset
    push_seq(64'h5000, 3, -1);
    send_cmd(64'h5000, 7'd3);
    wait_done("post_mid");

    repeat (3) @(negedge clk);
    chk("ar_q_drained", exp_ar_q.size(), 0);
    chk("blk_q_drained", exp_blk_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
